// File: rtl/mult32s_rr_scheduler.sv
// mult32s_rr_scheduler: round-robin arbiter sharing one pipelined 32x32 signed multiplier,
// tagging each issue so the product returns to its owner MUL_LAT cycles later.
module mult32s_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arb_en,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [31:0]           mul_a,
  output logic [31:0]           mul_b,
  input  logic [63:0]           mul_p,
  output logic                  resp_valid,
  output logic [ID_W-1:0]       resp_id,
  output logic [63:0]           resp_product,
  output logic                  busy,
  output logic [31:0]           op_count
);
  logic [ID_W-1:0]    r_rr_ptr;
  logic [MUL_LAT-1:0] r_vld;
  logic [ID_W-1:0]    r_id [MUL_LAT];
  logic [31:0]        r_op_count;
  logic               w_hit;
  logic               w_act;
  logic [ID_W-1:0]    w_g;
  // Scan downward so the last hit wins, i.e. the nearest set bit at or after rr_ptr.
  always_comb begin
    int idx;
    w_hit = 1'b0;
    w_g   = '0;
    idx   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(r_rr_ptr) + k;
      idx = (idx >= NUM_REQ) ? idx - NUM_REQ : idx;
      if (req_valid[idx]) begin
        w_hit = 1'b1;
        w_g   = ID_W'(idx);
      end
    end
  end
  assign w_act        = rst_n & arb_en & w_hit;
  assign req_ready    = w_act ? (NUM_REQ'(1) << w_g) : '0;
  assign mul_a        = w_act ? req_a[32*w_g +: 32] : '0;
  assign mul_b        = w_act ? req_b[32*w_g +: 32] : '0;
  assign resp_valid   = r_vld[MUL_LAT-1];
  assign resp_id      = r_id[MUL_LAT-1];
  assign resp_product = resp_valid ? mul_p : '0;
  assign busy         = |r_vld;
  assign op_count     = r_op_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_vld      <= '0;
      r_op_count <= '0;
      for (int i = 0; i < MUL_LAT; i++) r_id[i] <= '0;
    end else begin
      if (w_act) r_rr_ptr <= (w_g == ID_W'(NUM_REQ - 1)) ? '0 : w_g + 1'b1;
      r_vld[0]   <= w_act;
      r_id[0]    <= w_act ? w_g : '0;
      for (int i = 1; i < MUL_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_id[i]  <= r_id[i-1];
      end
      r_op_count <= r_op_count + 32'(w_act);
    end
  end
endmodule

// File: tb/tb_mult32s_rr_scheduler.sv
// tb_mult32s_rr_scheduler: scoreboard bench with a behavioural 2-stage signed multiplier.
module tb_mult32s_rr_scheduler;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         arb_en;
  logic [3:0]   req_valid;
  logic [127:0] req_a, req_b;
  logic [3:0]   req_ready;
  logic [31:0]  mul_a, mul_b;
  logic [63:0]  mul_p;
  logic         resp_valid;
  logic [1:0]   resp_id;
  logic [63:0]  resp_product;
  logic         busy;
  logic [31:0]  op_count;

  mult32s_rr_scheduler dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req_valid(req_valid),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .mul_a(mul_a),
    .mul_b(mul_b), .mul_p(mul_p), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_product(resp_product), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  logic [31:0] ma_q, mb_q;
  always @(posedge clk) begin
    ma_q  <= mul_a;
    mb_q  <= mul_b;
    mul_p <= longint'($signed(ma_q)) * longint'($signed(mb_q));
  end

  typedef struct {
    int          due;
    int          id;
    logic [63:0] p;
  } ent_t;
  ent_t        sb[$];
  int          gseq[$];
  int          rids[$];
  logic [63:0] rprod[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          m_ptr = 0;
  logic [31:0] m_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    int   g;
    ent_t e;
    cyc++;
    if (!rst_n) begin
      sb.delete();
      m_ptr = 0;
      m_cnt = 0;
    end
    chk("busy", 64'(busy), 64'(sb.size() != 0));
    chk("op_count", 64'(op_count), 64'(m_cnt));
    if (resp_valid) begin
      if (sb.size() == 0) chk("spurious_resp", 64'(resp_valid), 64'd0);
      else begin
        e = sb.pop_front();
        chk("resp_due", 64'(cyc), 64'(e.due));
        chk("resp_id", 64'(resp_id), 64'(e.id));
        chk("resp_product", resp_product, e.p);
        rids.push_back(int'(resp_id));
        rprod.push_back(resp_product);
      end
    end else begin
      chk("idle_product", resp_product, 64'd0);
      if (sb.size() != 0 && sb[0].due == cyc) chk("missing_resp", 64'(resp_valid), 64'd1);
    end
    g = -1;
    if (rst_n && arb_en)
      for (int k = 3; k >= 0; k--)
        if (req_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
    chk("req_ready", 64'(req_ready), (g >= 0) ? 64'(4'b1 << g) : 64'd0);
    chk("mul_a", 64'(mul_a), (g >= 0) ? 64'(req_a[32*g +: 32]) : 64'd0);
    chk("mul_b", 64'(mul_b), (g >= 0) ? 64'(req_b[32*g +: 32]) : 64'd0);
    if (g >= 0) begin
      e.due = cyc + 2;
      e.id  = g;
      e.p   = longint'($signed(req_a[32*g +: 32])) * longint'($signed(req_b[32*g +: 32]));
      sb.push_back(e);
      gseq.push_back(g);
      m_ptr = (g + 1) % 4;
      m_cnt = m_cnt + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic clear_log();
    gseq.delete();
    rids.delete();
    rprod.delete();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    int exp3[8];
    int exp4[5];
    exp3 = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp4 = '{1, 3, 1, 3, 2};
    rst_n     = 1'b0;
    arb_en    = 1'($urandom);
    req_valid = 4'($urandom);
    for (int i = 0; i < 4; i++) set_op(i, $urandom, $urandom);
    step(3);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_mul_a", 64'(mul_a), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n     = 1'b1;
    arb_en    = 1'b1;
    req_valid = 4'b0;
    step(3);
    chk("idle_ready", 64'(req_ready), 64'd0);
    clear_log();
    set_op(0, 32'd7, -32'sd3);
    req_valid = 4'b0001;
    step(1);
    req_valid = 4'b0;
    step(3);
    chk("single_n", 64'(rprod.size()), 64'd1);
    chk("single_prod", rprod[0], 64'hFFFFFFFFFFFFFFEB);
    chk("single_id", 64'(rids[0]), 64'd0);
    chk("single_cnt", 64'(op_count), 64'd1);
    pulse_reset();
    clear_log();
    for (int i = 0; i < 4; i++) set_op(i, $urandom, $urandom);
    req_valid = 4'hF;
    step(8);
    req_valid = 4'h0;
    step(3);
    chk("rr_n", 64'(rprod.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk("rr_grant", 64'(gseq[i]), 64'(exp3[i]));
      chk("rr_rid", 64'(rids[i]), 64'(exp3[i]));
    end
    clear_log();
    req_valid = 4'hA;
    step(4);
    req_valid = 4'h4;
    step(1);
    req_valid = 4'h0;
    step(3);
    for (int i = 0; i < 5; i++) chk("skip_grant", 64'(gseq[i]), 64'(exp4[i]));
    clear_log();
    set_op(0, 32'h80000000, 32'h80000000);
    req_valid = 4'b0001;
    step(1);
    set_op(0, 32'h7FFFFFFF, 32'h80000000);
    step(1);
    req_valid = 4'b0;
    step(3);
    chk("corner_min_min", rprod[0], 64'h4000000000000000);
    chk("corner_max_min", rprod[1], 64'hC000000080000000);
    clear_log();
    req_valid = 4'hF;
    step(3);
    arb_en = 1'b0;
    step(1);
    chk("drain_busy_hi", 64'(busy), 64'd1);
    step(1);
    chk("drain_busy_lo", 64'(busy), 64'd0);
    step(2);
    chk("drain_n", 64'(rprod.size()), 64'd3);
    arb_en = 1'b1;
    req_valid = 4'h0;
    step(1);
    clear_log();
    req_valid = 4'hF;
    step(2);
    req_valid = 4'h0;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(4);
    chk("rst_mid_n", 64'(rprod.size()), 64'd0);
    chk("rst_mid_cnt", 64'(op_count), 64'd0);
    force dut.r_op_count = 32'hFFFFFFFE;
    m_cnt = 32'hFFFFFFFE;
    #1;
    release dut.r_op_count;
    req_valid = 4'b0001;
    step(1);
    chk("wrap_max", 64'(op_count), 64'hFFFFFFFF);
    step(1);
    chk("wrap_zero", 64'(op_count), 64'd0);
    req_valid = 4'b0;
    step(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/mult32s_rr_scheduler.md
Name: mult32s_rr_scheduler

Overview:
- Round-robin scheduler that shares one registered 32x32 signed Booth multiplier among NUM_REQ requesters.
- The multiplier has one input register stage and one output register stage and no stall input.
- Each cycle the scheduler grants at most one requester and drives its operands to the multiplier.
- It tags each issued operation and returns the 64-bit product to the owning requester exactly MUL_LAT cycles later.
- It sits between compute clients (MAC lanes, address generators) and the shared multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, tag width; NUM_REQ <= 2**ID_W is required.
- MUL_LAT, 2, cycles from operands presented on mul_a/mul_b to a valid mul_p (input reg + output reg).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- arb_en  input  1  when 0, no new grants; in-flight operations still complete.
- req_valid  input  NUM_REQ  per-requester operation request.
- req_a  input  NUM_REQ*32  multiplicands; requester i occupies bits [32i+31:32i].
- req_b  input  NUM_REQ*32  multipliers, same packing.
- req_ready  output  NUM_REQ  one-hot grant; the request is accepted when valid and ready are both high.
- mul_a  output  32  multiplicand to the shared multiplier.
- mul_b  output  32  multiplier operand to the shared multiplier.
- mul_p  input  64  signed product from the shared multiplier.
- resp_valid  output  1  product valid this cycle.
- resp_id  output  ID_W  requester index owning resp_product.
- resp_product  output  64  equals mul_p when resp_valid=1, else 0.
- busy  output  1  high while any issued operation is in flight.
- op_count  output  32  total accepted operations; wraps at 2**32.

Behaviour:
- Reset (async assert, sync release): rr_ptr=0, tag pipeline cleared, op_count=0, resp_valid=0, resp_id=0, resp_product=0, busy=0. While rst_n=0, req_ready=0 and mul_a/mul_b=0.
- Grant (combinational):
  - If arb_en=1 and any req_valid is set, grant the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - req_ready is one-hot on the granted bit and zero elsewhere.
  - No grant when arb_en=0 or req_valid=0.
- Operands: mul_a/mul_b = operands of the granted requester; 0 when nothing is granted.
- Pointer: on a grant to requester g, rr_ptr <= (g+1) mod NUM_REQ. Otherwise rr_ptr holds.
- Fairness: any continuously asserted request is granted within NUM_REQ cycles while arb_en=1.
- Tag pipeline:
  - MUL_LAT stages, each holding {valid, id}. Stage 0 captures {grant, g} at the grant edge; the stages shift every cycle unconditionally.
  - resp_valid and resp_id come from the last stage. An operation accepted in cycle t yields resp_valid=1 in cycle t+MUL_LAT.
- Throughput: one operation per cycle, back-to-back, with no bubbles.
- Results are in-order. Responses have no backpressure; requesters must sink them.
- busy = OR of all stage valid bits. It does not include the current-cycle grant.
- op_count increments by 1 per accepted operation and wraps 0xFFFFFFFF -> 0.
- Single requester: that requester is granted every cycle regardless of rr_ptr.
- arb_en falling mid-stream: already accepted operations still return. busy falls MUL_LAT cycles after the last grant.
- Reset mid-operation: all in-flight tags are dropped and no resp_valid follows. The multiplier's stale mul_p values are ignored.
- Signed arithmetic is performed entirely by the multiplier; the scheduler passes data through unmodified.

Test Plan:
1. Reset → idle: assert rst_n=0 with random inputs → req_ready=0, resp_valid=0, op_count=0, busy=0. Release reset, drive req_valid=0 → outputs stay idle.
2. Single request: req_valid=0001, req_a[0]=7, req_b[0]=-3 accepted in cycle t → resp_valid=1, resp_id=0, resp_product=0xFFFFFFFFFFFFFFEB at t+2; op_count=1.
3. Round-robin under full load: req_valid=1111 held for 8 cycles with distinct operands → grants 0,1,2,3,0,1,2,3; 8 responses with ids in the same order and products matching a reference model; no bubbles.
4. Fairness skip: req_valid=1010 with rr_ptr=0 → grants 1,3,1,3. Then req_valid=0100 → grant 2 on the next cycle.
5. Corner operands: 0x80000000 × 0x80000000 → 0x4000000000000000. 0x7FFFFFFF × 0x80000000 → 0xC000000080000000.
6. Disruption and wrap:
   - arb_en dropped after 3 grants → exactly 3 responses follow, busy=0 two cycles after the last grant.
   - rst_n pulsed low while two operations are in flight → no responses, op_count=0.
   - op_count preloaded near wrap via repeated ops (or a forced value) goes 0xFFFFFFFF → 0.
